// File: rtl/mdu_iterative.sv
`default_nettype none
// ==========================================================================
// mdu_iterative: iterative 32x32 shift-add multiply / restoring divide that
// writes hi/lo through two register-file ports. Signed ops via MDU_SIGNED_EN.
// Revision 1.0
// ==========================================================================
module mdu_iterative #(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       dst_hi,
   input  logic [4:0]       dst_lo,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic             RegWrite,
   output logic [4:0]       WriteReg1,
   output logic [WIDTH-1:0] WriteData1,
   output logic             RegWrite2,
   output logic [4:0]       WriteReg2,
   output logic [WIDTH-1:0] WriteData2
);
   localparam int CW = $clog2(ITER);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WRITE = 2'd2} state_t;

   state_t             state_q, state_d;
   logic               is_div_q, is_div_d;
   logic               sign_res_q, sign_res_d;
   logic               sign_rem_q, sign_rem_d;
   logic [4:0]         dst_hi_q, dst_hi_d;
   logic [4:0]         dst_lo_q, dst_lo_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;

   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               dbz_q, dbz_d;
   logic               we1_q, we1_d;
   logic               we2_q, we2_d;
   logic [4:0]         wreg1_q, wreg1_d;
   logic [4:0]         wreg2_q, wreg2_d;
   logic [WIDTH-1:0]   wdata1_q, wdata1_d;
   logic [WIDTH-1:0]   wdata2_q, wdata2_d;

   logic               is_signed;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum, div_diff;
   logic [2*WIDTH-1:0] step_acc, prod_fix;
   logic [WIDTH-1:0]   res_hi, res_lo;

   always_comb begin
`ifdef MDU_SIGNED_EN
      is_signed = op[0];
      mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
      mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;
`else
      is_signed = op[0] & 1'b0;
      mag_a     = a;
      mag_b     = b;
`endif
      // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q & {WIDTH{acc_q[0]}}};
      // Divide: acc = {remainder, dividend/quotient}, shifted left one bit per step.
      div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
      if (is_div_q) begin
         step_acc = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         step_acc = {mul_sum, acc_q[WIDTH-1:1]};
      end

      prod_fix = sign_res_q ? -step_acc : step_acc;
      if (is_div_q) begin
         res_lo = sign_res_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
         res_hi = sign_rem_q ? -step_acc[2*WIDTH-1:WIDTH] : step_acc[2*WIDTH-1:WIDTH];
      end else begin
         res_lo = prod_fix[WIDTH-1:0];
         res_hi = prod_fix[2*WIDTH-1:WIDTH];
      end
   end

   always_comb begin
      state_d    = state_q;
      is_div_d   = is_div_q;
      sign_res_d = sign_res_q;
      sign_rem_d = sign_rem_q;
      dst_hi_d   = dst_hi_q;
      dst_lo_d   = dst_lo_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opb_d      = opb_q;
      done_d     = 1'b0;
      dbz_d      = 1'b0;
      we1_d      = 1'b0;
      we2_d      = 1'b0;
      wreg1_d    = wreg1_q;
      wreg2_d    = wreg2_q;
      wdata1_d   = wdata1_q;
      wdata2_d   = wdata2_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (op[1] && (b == '0)) begin
                  state_d  = WRITE;
                  done_d   = 1'b1;
                  dbz_d    = 1'b1;
                  wreg1_d  = dst_hi;
                  wreg2_d  = dst_lo;
                  wdata1_d = a;
                  wdata2_d = '1;
                  we1_d    = (dst_hi != 5'd0) && (dst_hi != dst_lo);
                  we2_d    = (dst_lo != 5'd0);
               end else begin
                  state_d    = RUN;
                  is_div_d   = op[1];
                  dst_hi_d   = dst_hi;
                  dst_lo_d   = dst_lo;
                  sign_res_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  sign_rem_d = is_signed & a[WIDTH-1];
                  cnt_d      = CW'(ITER - 1);
                  acc_d      = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                  opb_d      = op[1] ? mag_b : mag_a;
               end
            end
         end
         RUN: begin
            acc_d = step_acc;
            cnt_d = cnt_q - 1'b1;
            // Final step: outputs are registered straight from the fixed-up result.
            if (cnt_q == '0) begin
               state_d  = WRITE;
               done_d   = 1'b1;
               wreg1_d  = dst_hi_q;
               wreg2_d  = dst_lo_q;
               wdata1_d = res_hi;
               wdata2_d = res_lo;
               we1_d    = (dst_hi_q != 5'd0) && (dst_hi_q != dst_lo_q);
               we2_d    = (dst_lo_q != 5'd0);
            end
         end
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         is_div_q   <= 1'b0;
         sign_res_q <= 1'b0;
         sign_rem_q <= 1'b0;
         dst_hi_q   <= '0;
         dst_lo_q   <= '0;
         cnt_q      <= '0;
         acc_q      <= '0;
         opb_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         dbz_q      <= 1'b0;
         we1_q      <= 1'b0;
         we2_q      <= 1'b0;
         wreg1_q    <= '0;
         wreg2_q    <= '0;
         wdata1_q   <= '0;
         wdata2_q   <= '0;
      end else begin
         state_q    <= state_d;
         is_div_q   <= is_div_d;
         sign_res_q <= sign_res_d;
         sign_rem_q <= sign_rem_d;
         dst_hi_q   <= dst_hi_d;
         dst_lo_q   <= dst_lo_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opb_q      <= opb_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         dbz_q      <= dbz_d;
         we1_q      <= we1_d;
         we2_q      <= we2_d;
         wreg1_q    <= wreg1_d;
         wreg2_q    <= wreg2_d;
         wdata1_q   <= wdata1_d;
         wdata2_q   <= wdata2_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign RegWrite    = we1_q;
   assign RegWrite2   = we2_q;
   assign WriteReg1   = wreg1_q;
   assign WriteReg2   = wreg2_q;
   assign WriteData1  = wdata1_q;
   assign WriteData2  = wdata2_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iterative.sv
`default_nettype none
// ==========================================================================
// tb_mdu_iterative: directed vector table plus busy/reset corner sequences.
// Revision 1.0
// ==========================================================================
module tb_mdu_iterative;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0, b = '0;
   logic [4:0]  dst_hi = '0, dst_lo = '0;
   logic        busy, done, div_by_zero;
   logic        RegWrite, RegWrite2;
   logic [4:0]  WriteReg1, WriteReg2;
   logic [31:0] WriteData1, WriteData2;

   int checks = 0;
   int errors = 0;

   mdu_iterative #(.WIDTH(32), .ITER(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .dst_hi(dst_hi), .dst_lo(dst_lo), .busy(busy), .done(done),
      .div_by_zero(div_by_zero), .RegWrite(RegWrite), .WriteReg1(WriteReg1),
      .WriteData1(WriteData1), .RegWrite2(RegWrite2), .WriteReg2(WriteReg2),
      .WriteData2(WriteData2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  dh;
      logic [4:0]  dl;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        we1;
      logic        we2;
      logic        dbz;
   } vec_t;

`ifdef MDU_SIGNED_EN
   localparam logic [31:0] MUL_N3_HI = 32'hFFFFFFFF;
   localparam logic [31:0] DIV_N7_LO = 32'hFFFFFFFD;
   localparam logic [31:0] DIV_N7_HI = 32'hFFFFFFFF;
   localparam logic [31:0] DIV_MIN_LO = 32'h80000000;
   localparam logic [31:0] DIV_MIN_HI = 32'h00000000;
`else
   localparam logic [31:0] MUL_N3_HI = 32'h00000006;
   localparam logic [31:0] DIV_N7_LO = 32'h7FFFFFFC;
   localparam logic [31:0] DIV_N7_HI = 32'h00000001;
   localparam logic [31:0] DIV_MIN_LO = 32'h00000000;
   localparam logic [31:0] DIV_MIN_HI = 32'h80000000;
`endif

   localparam int NV = 12;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one operation, measure latency to done and check the write cycle.
   task automatic run_vec(input vec_t v, input int idx);
      int  lat;
      int  exp_lat;
      exp_lat = v.dbz ? 1 : 33;
      @(negedge clk);
      start = 1'b1; op = v.op; a = v.a; b = v.b; dst_hi = v.dh; dst_lo = v.dl;
      @(posedge clk); #1;
      start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
      dst_hi = 5'($urandom); dst_lo = 5'($urandom);
      lat = 1;
      while (!done && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      chk($sformatf("v%0d latency", idx), 64'(lat), 64'(exp_lat));
      chk($sformatf("v%0d done", idx), 64'(done), 64'd1);
      chk($sformatf("v%0d dbz", idx), 64'(div_by_zero), 64'(v.dbz));
      chk($sformatf("v%0d we1/we2", idx), {62'd0, RegWrite, RegWrite2}, {62'd0, v.we1, v.we2});
      chk($sformatf("v%0d wreg", idx), {54'd0, WriteReg1, WriteReg2}, {54'd0, v.dh, v.dl});
      chk($sformatf("v%0d hi", idx), 64'(WriteData1), 64'(v.hi));
      chk($sformatf("v%0d lo", idx), 64'(WriteData2), 64'(v.lo));
      @(posedge clk); #1;
      chk($sformatf("v%0d idle after", idx), {60'd0, busy, done, RegWrite, RegWrite2}, 64'd0);
      chk($sformatf("v%0d data held", idx), {WriteData1, WriteData2}, {v.hi, v.lo});
   endtask

   initial begin
      int  lat;
      logic bad;

      vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  5'd9,  32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b1, 1'b0};
      vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'd7,        5'd10, 5'd11, MUL_N3_HI,    32'hFFFFFFEB, 1'b1, 1'b1, 1'b0};
      vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'd2,        5'd12, 5'd13, DIV_N7_HI,    DIV_N7_LO,    1'b1, 1'b1, 1'b0};
      vecs[3]  = '{2'b10, 32'd100,      32'd7,        5'd14, 5'd15, 32'd2,        32'd14,       1'b1, 1'b1, 1'b0};
      vecs[4]  = '{2'b10, 32'd100,      32'd0,        5'd1,  5'd2,  32'd100,      32'hFFFFFFFF, 1'b1, 1'b1, 1'b1};
      vecs[5]  = '{2'b00, 32'd3,        32'd4,        5'd5,  5'd5,  32'd0,        32'd12,       1'b0, 1'b1, 1'b0};
      vecs[6]  = '{2'b00, 32'h00010000, 32'h00010000, 5'd0,  5'd4,  32'd1,        32'd0,        1'b0, 1'b1, 1'b0};
      vecs[7]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 5'd3,  5'd6,  DIV_MIN_HI,   DIV_MIN_LO,   1'b1, 1'b1, 1'b0};
      vecs[8]  = '{2'b00, 32'hFFFFFFFF, 32'd2,        5'd16, 5'd17, 32'd1,        32'hFFFFFFFE, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{2'b10, 32'd5,        32'd10,       5'd18, 5'd19, 32'd5,        32'd0,        1'b1, 1'b1, 1'b0};
      vecs[10] = '{2'b10, 32'h12345678, 32'h00001000, 5'd20, 5'd21, 32'h00000678, 32'h00012345, 1'b1, 1'b1, 1'b0};
      vecs[11] = '{2'b11, 32'hFFFFFFF9, 32'd0,        5'd7,  5'd0,  32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1};

      #12;
      chk("reset outputs", {busy, done, div_by_zero, RegWrite, RegWrite2, WriteReg1, WriteReg2, 44'd0},
          64'd0);
      chk("reset data", {WriteData1, WriteData2}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

      // start while busy is ignored: the first operation's result must come out.
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7; dst_hi = 5'd22; dst_lo = 5'd23;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy after start", 64'(busy), 64'd1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      start = 1'b1; op = 2'b10; a = 32'd50; b = 32'd3; dst_hi = 5'd24; dst_lo = 5'd25;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 6;
      while (!done && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("busy-start latency", 64'(lat), 64'd33);
      chk("busy-start result", {WriteData1, WriteData2}, {32'd0, 32'd42});
      chk("busy-start wreg", {54'd0, WriteReg1, WriteReg2}, {54'd0, 5'd22, 5'd23});
      @(posedge clk); #1;
      chk("busy-start idle", 64'(busy), 64'd0);

      // Reset in the middle of an operation discards it without a write.
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9; dst_hi = 5'd26; dst_lo = 5'd27;
      @(posedge clk); #1;
      start = 1'b0;
      bad = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
         bad = bad | RegWrite | RegWrite2 | done;
      end
      #2 rst_n = 1'b0;
      #1;
      chk("busy cleared by reset", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (31) begin
         @(posedge clk); #1;
         bad = bad | RegWrite | RegWrite2 | done | busy;
      end
      chk("no write after reset", 64'(bad), 64'd0);

      run_vec(vecs[3], 100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
`default_nettype wire

// File: doc/mdu_iterative.md
# mdu_iterative

Iterative 32-bit multiply/divide unit for the 32-bit MIPS processor. Accepts one operation per start pulse, computes a 64-bit result over 32 iterations, and writes it back through the register file's two write ports in a single cycle: hi/remainder on port 1, lo/quotient on port 2. Sits directly upstream of the register file, in parallel with the ALU writeback path.

## Interface
- `WIDTH`, 32: operand width; the only supported value is 32.
- `ITER`, 32: iteration count; must equal `WIDTH`.

- `clk`  in  1  clock; all state changes on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  operation request; sampled only in IDLE.
- `op`  in  2  00 multu, 01 mult, 10 divu, 11 div.
- `a`, `b`  in  32 each  multiplicand/dividend (`a`), multiplier/divisor (`b`).
- `dst_hi`, `dst_lo`  in  5 each  destination registers for hi/remainder and lo/quotient.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse in the WRITE cycle.
- `div_by_zero`  out  1  qualified by `done`; set for a divide with `b`==0.
- `RegWrite`, `WriteReg1`, `WriteData1`  out  1/5/32  hi/remainder write to register-file port 1.
- `RegWrite2`, `WriteReg2`, `WriteData2`  out  1/5/32  lo/quotient write to register-file port 2.

## Operation
- States: IDLE, RUN, WRITE.
- IDLE to RUN:
  - Taken on `start`=1, except divide with `b`==0.
  - Latches `op`, `dst_hi`, `dst_lo`.
  - Latches |a| and |b| when the op is signed; latches raw values otherwise.
  - Records result sign = a[31]^b[31]; records remainder sign = a[31].
  - Loads counter = 31.
- IDLE to WRITE: on `start` with a divide and `b`==0. Result is hi=`a` (raw), lo=32'hFFFFFFFF, `div_by_zero`=1.
- RUN, multiply: unsigned shift-add on a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- RUN, divide: restoring division, one quotient bit per cycle, MSB first. Remainder is 32-bit; compare/subtract is 33-bit.
- RUN: counter decrements each cycle. Counter==0 transitions to WRITE.
- WRITE, signed fixup (combinational from state):
  - mult: 64-bit product negated when result sign=1.
  - div: quotient negated when result sign=1; remainder negated when remainder sign=1.
  - 32'h80000000 / 32'hFFFFFFFF gives lo=32'h80000000, hi=0. This falls out of the algorithm; no special case.
- WRITE outputs:
  - `RegWrite`=1, `WriteReg1`=dst_hi, `WriteData1`=hi.
  - `RegWrite2`=1, `WriteReg2`=dst_lo, `WriteData2`=lo.
  - `done`=1. Next state IDLE.
- Write suppression:
  - Destination 0: that port's write enable is forced 0.
  - `dst_hi`==`dst_lo`: `RegWrite` is forced 0, so only lo is written. This avoids a same-address dual-write conflict in the register file.
- `start` while `busy` is ignored, with no queuing.
- `op`, `a`, `b`, `dst_*` are don't-care outside the start cycle.

## Timing
- Reset values: state IDLE, all outputs 0 (`busy`, `done`, `div_by_zero`, both write enables, `WriteReg*`, `WriteData*`).
- `rst_n` low mid-operation: immediate return to IDLE, no write issued, partial result discarded.
- Normal latency, with `start` sampled at edge N:
  - `busy` is high from N+1.
  - RUN occupies cycles N+1..N+32.
  - WRITE/`done` is in cycle N+33.
  - `busy` is 0 at N+34, and a new `start` is accepted at that edge.
- Divide-by-zero latency: WRITE in cycle N+1; IDLE again at N+2.
- Write enables and `done` are high for exactly one cycle per operation. The register file captures on the posedge ending the WRITE cycle.
- `WriteData*` and `WriteReg*` hold their last values outside WRITE; write enables gate them.

## Configuration
- Macro: `MDU_SIGNED_EN`.
- Defined:
  - `op[0]` selects signed (mult/div).
  - Operands are converted to magnitudes and the result is fixed up as above.
  - Adds two 32-bit negators on input and one 64-bit negator on output.
- Undefined:
  - `op[0]` is ignored, so 01 behaves as 00 and 11 as 10.
  - No sign logic is synthesized.
  - Divide-by-zero behaviour is unchanged.

## Test plan
- multu: a=32'hFFFFFFFF, b=32'hFFFFFFFF, dst_hi=8, dst_lo=9 -> in cycle N+33, `RegWrite`/`RegWrite2`=1, r8=32'hFFFFFFFE, r9=32'h00000001; `busy` 0 at N+34.
- mult (MDU_SIGNED_EN): a=-3, b=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB. Without the macro, the same stimulus gives hi=32'h00000006, lo=32'hFFFFFFEB.
- div (MDU_SIGNED_EN): a=-7, b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). divu 100/7 -> lo=14, hi=2.
- divu: a=100, b=0 -> `done` and `div_by_zero`=1 in cycle N+1, hi=100, lo=32'hFFFFFFFF; `busy` 0 at N+2.
- `start` pulsed again at N+5 with different operands -> ignored, first result written at N+33. Second case: `rst_n` low at N+10 -> `busy`=0 immediately, no write enable through N+40.
- Write suppression:
  - dst_hi=dst_lo=5 -> only `RegWrite2`=1 in WRITE.
  - dst_hi=0, dst_lo=4 -> `RegWrite`=0, `RegWrite2`=1.
